// File: rtl/argsel_pkg.sv
// argsel_pkg: mode encoding and elaboration helpers that size the argsel_tree comparator pipeline
package argsel_pkg;
    typedef enum logic {ARG_MAX = 1'b0, ARG_MIN = 1'b1} mode_e;
    function automatic int num_stages(input int n, input int radix);
        int s = 0;
        int cap = 1;
        while (cap < n) begin
            cap = cap * radix;
            s++;
        end
        return s;
    endfunction
    function automatic int lanes_at(input int n, input int radix, input int stage);
        int l = n;
        for (int i = 0; i < stage; i++) l = (l + radix - 1) / radix;
        return l;
    endfunction
    function automatic int nodes_at(input int n, input int radix, input int stage);
        return (lanes_at(n, radix, stage) + radix - 1) / radix;
    endfunction
endpackage

// File: rtl/argsel_node.sv
// argsel_node: RADIX-lane comparator (clk, reset, en, mode_i, lanes_i in; win_c combinational winner, win_q registered winner out)
module argsel_node import argsel_pkg::*; #(
    parameter int RADIX  = 4,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5,
    parameter int SIGNED = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic                                 mode_i,
    input  logic [RADIX*(DATA_W+IDX_W+1)-1:0]    lanes_i,
    output logic [DATA_W+IDX_W:0]                win_c,
    output logic [DATA_W+IDX_W:0]                win_q
);
    localparam int LW = DATA_W + IDX_W + 1;
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              pad;
    } lane_t;
    lane_t lane [RADIX];
    lane_t best;
    // strict compare so an equal score never displaces the lower-index lane already held
    function automatic logic beats(input lane_t a, input lane_t b, input logic mn);
        logic gt = SIGNED != 0 ? $signed(a.data) > $signed(b.data) : a.data > b.data;
        logic lt = SIGNED != 0 ? $signed(a.data) < $signed(b.data) : a.data < b.data;
        return !a.pad && (b.pad || (mn ? lt : gt));
    endfunction
    always_comb begin
        for (int r = 0; r < RADIX; r++) lane[r] = lane_t'(lanes_i[r*LW +: LW]);
        best = lane[0];
        for (int r = 1; r < RADIX; r++) best = beats(lane[r], best, mode_i == ARG_MIN) ? lane[r] : best;
    end
    assign win_c = best;
    always_ff @(posedge clk or posedge reset)
        if (reset) win_q <= '0;
        else if (en) win_q <= best;
endmodule

// File: rtl/argsel_tree.sv
// argsel_tree: pipelined arg-max/arg-min over NUM_CLASSES scores (in: clk, reset, data_in, valid_i, mode_i, thresh_i; out: data_out, idx_out, conf_o, valid_o, stable_idx_o, stable_vld_o); TEMPORAL_FILTER_EN enables the winner stabiliser
module argsel_tree import argsel_pkg::*; #(
    parameter int NUM_CLASSES = 24,
    parameter int DATA_W      = 8,
    parameter int RADIX       = 4,
    parameter int SIGNED      = 0,
    parameter int HOLD_FRAMES = 3,
    localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLASSES*DATA_W-1:0] data_in,
    input  logic                          valid_i,
    input  logic                          mode_i,
    input  logic [DATA_W-1:0]             thresh_i,
    output logic [DATA_W-1:0]             data_out,
    output logic [IDX_W-1:0]              idx_out,
    output logic                          conf_o,
    output logic                          valid_o,
    output logic [IDX_W-1:0]              stable_idx_o,
    output logic                          stable_vld_o
);
    localparam int S  = num_stages(NUM_CLASSES, RADIX);
    localparam int LW = DATA_W + IDX_W + 1;
    localparam logic [LW-1:0] PAD = LW'(1);
    logic [LW-1:0] lane  [S+1][NUM_CLASSES];
    logic [LW-1:0] win_c [S][NUM_CLASSES];
    logic [S:1] vld_q, md_q;
    logic [S:0] vld, md;
    logic [DATA_W-1:0] fin;
    logic ge, le;
    assign vld = {vld_q, valid_i};
    assign md  = {md_q, mode_i};
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            vld_q <= '0;
            md_q  <= '0;
        end else begin
            vld_q <= vld[S-1:0];
            md_q  <= md[S-1:0];
        end
    for (genvar j = 0; j < NUM_CLASSES; j++) begin : g_in
        assign lane[0][j] = {data_in[DATA_W*j +: DATA_W], IDX_W'(j), 1'b0};
    end
    for (genvar s = 0; s < S; s++) begin : g_st
        localparam int LIN = lanes_at(NUM_CLASSES, RADIX, s);
        localparam int NN  = nodes_at(NUM_CLASSES, RADIX, s);
        for (genvar k = 0; k < NN; k++) begin : g_nd
            logic [RADIX*LW-1:0] lin;
            for (genvar r = 0; r < RADIX; r++) begin : g_l
                if (k*RADIX + r < LIN) begin : g_u
                    assign lin[r*LW +: LW] = lane[s][k*RADIX + r];
                end else begin : g_p
                    assign lin[r*LW +: LW] = PAD;
                end
            end
            argsel_node #(.RADIX(RADIX), .DATA_W(DATA_W), .IDX_W(IDX_W), .SIGNED(SIGNED)) u_node (
                .clk(clk), .reset(reset), .en(vld[s]), .mode_i(md[s]),
                .lanes_i(lin), .win_c(win_c[s][k]), .win_q(lane[s+1][k])
            );
        end
    end
    // the final node's register is the output register, so it resets to 0 and holds between strobes
    assign data_out = lane[S][0][LW-1 -: DATA_W];
    assign idx_out  = lane[S][0][IDX_W:1];
    assign valid_o  = vld_q[S];
    // confidence is judged on the winner entering the last register so it lines up with data_out
    assign fin = win_c[S-1][0][LW-1 -: DATA_W];
    assign ge  = SIGNED != 0 ? $signed(fin) >= $signed(thresh_i) : fin >= thresh_i;
    assign le  = SIGNED != 0 ? $signed(fin) <= $signed(thresh_i) : fin <= thresh_i;
    always_ff @(posedge clk or posedge reset)
        if (reset) conf_o <= 1'b0;
        else if (vld[S-1]) conf_o <= md[S-1] == ARG_MIN ? le : ge;
`ifdef TEMPORAL_FILTER_EN
    localparam int CW = $clog2(HOLD_FRAMES + 1);
    logic [IDX_W-1:0] cand, cand_n;
    logic [CW-1:0] cnt, cnt_n;
    logic promote;
    always_comb begin
        cand_n  = conf_o && idx_out != cand ? idx_out : cand;
        cnt_n   = !conf_o ? '0 : idx_out != cand ? CW'(1) : cnt == CW'(HOLD_FRAMES) ? cnt : cnt + 1'b1;
        promote = valid_o && cnt_n == CW'(HOLD_FRAMES) && cand_n != stable_idx_o;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cand         <= '0;
            cnt          <= '0;
            stable_idx_o <= '0;
            stable_vld_o <= 1'b0;
        end else begin
            stable_vld_o <= promote;
            if (valid_o) begin
                cand <= cand_n;
                cnt  <= cnt_n;
            end
            if (promote) stable_idx_o <= cand_n;
        end
`else
    assign stable_idx_o = idx_out;
    assign stable_vld_o = valid_o;
`endif
endmodule

// File: tb/tb_argsel_tree.sv
// tb_argsel_tree: directed and randomized checks of argsel_tree against a behavioural selector model
`timescale 1ns/1ps
module tb_argsel_tree;
    localparam int N = 24, W = 8, NP = 7, H = 3;
    typedef struct {int due; int idx; int val; bit conf;} exp_t;
    logic clk = 0, reset = 1;
    logic [N*W-1:0] data_in = '0;
    logic [NP*W-1:0] data_p = '0;
    logic valid_i = 0, valid_p = 0, mode_i = 0, mode_p = 0;
    logic [W-1:0] thresh_i = 8'h80;
    logic [W-1:0] d_u, d_s, d_p;
    logic [4:0] i_u, i_s, si_u, si_s;
    logic [2:0] i_p, si_p;
    logic c_u, c_s, c_p, v_u, v_s, v_p, sv_u, sv_s, sv_p;
    int cyc = 0, n_chk = 0, n_err = 0;
    exp_t q[3][$];
    exp_t lst[3];
    int cand[3], cnt[3], stab[3];
    bit pend[3];

    argsel_tree #(.NUM_CLASSES(N), .DATA_W(W), .RADIX(4), .SIGNED(0), .HOLD_FRAMES(H)) dut_u (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_i(valid_i), .mode_i(mode_i), .thresh_i(thresh_i),
        .data_out(d_u), .idx_out(i_u), .conf_o(c_u), .valid_o(v_u), .stable_idx_o(si_u), .stable_vld_o(sv_u));
    argsel_tree #(.NUM_CLASSES(N), .DATA_W(W), .RADIX(4), .SIGNED(1), .HOLD_FRAMES(H)) dut_s (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_i(valid_i), .mode_i(mode_i), .thresh_i(thresh_i),
        .data_out(d_s), .idx_out(i_s), .conf_o(c_s), .valid_o(v_s), .stable_idx_o(si_s), .stable_vld_o(sv_s));
    argsel_tree #(.NUM_CLASSES(NP), .DATA_W(W), .RADIX(4), .SIGNED(0), .HOLD_FRAMES(H)) dut_p (
        .clk(clk), .reset(reset), .data_in(data_p), .valid_i(valid_p), .mode_i(mode_p), .thresh_i(thresh_i),
        .data_out(d_p), .idx_out(i_p), .conf_o(c_p), .valid_o(v_p), .stable_idx_o(si_p), .stable_vld_o(sv_p));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int key(input logic [W-1:0] x, input bit sgn);
        return sgn ? int'($signed(x)) : int'(x);
    endfunction

    // reference: scan scores in index order, keep the first strictly best one
    function automatic exp_t model(input logic [N*W-1:0] v, input int n, input bit sgn, input bit mn, input int due);
        exp_t e;
        int best = 0;
        int bk = 0;
        for (int j = 0; j < n; j++) begin
            int k = key(v[W*j +: W], sgn);
            if (j == 0 || (mn ? k < bk : k > bk)) begin
                best = j;
                bk = k;
            end
        end
        e.due = due;
        e.idx = best;
        e.val = int'(v[W*best +: W]);
        e.conf = mn ? bk <= key(thresh_i, sgn) : bk >= key(thresh_i, sgn);
        return e;
    endfunction

    task automatic flush();
        for (int u = 0; u < 3; u++) begin
            q[u].delete();
            lst[u] = '{0, 0, 0, 0};
            cand[u] = 0;
            cnt[u] = 0;
            stab[u] = 0;
            pend[u] = 0;
        end
    endtask

    task automatic put(input logic [N*W-1:0] v, input bit m);
        data_in = v;
        mode_i = m;
        valid_i = 1;
        q[0].push_back(model(v, N, 0, m, cyc + 3));
        q[1].push_back(model(v, N, 1, m, cyc + 3));
    endtask

    task automatic put_p(input logic [NP*W-1:0] v, input bit m);
        data_p = v;
        mode_p = m;
        valid_p = 1;
        q[2].push_back(model({{(N-NP)*W{1'b0}}, v}, NP, 0, m, cyc + 2));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        valid_i = 0;
        valid_p = 0;
    endtask

    task automatic send(input logic [N*W-1:0] v, input bit m);
        put(v, m);
        tick();
    endtask

    task automatic send_p(input logic [NP*W-1:0] v, input bit m);
        put_p(v, m);
        tick();
    endtask

    task automatic mon(input int u, input string t, input logic v, input logic [W-1:0] d, input logic [4:0] i,
                       input logic c, input logic [4:0] si, input logic sv);
        bit due;
        due = q[u].size() > 0 && q[u][0].due == cyc;
        chk({t, "_valid"}, v, due);
        if (due) lst[u] = q[u].pop_front();
        chk({t, "_data"}, d, lst[u].val);
        chk({t, "_idx"}, i, lst[u].idx);
        chk({t, "_conf"}, c, lst[u].conf);
`ifdef TEMPORAL_FILTER_EN
        chk({t, "_stable_vld"}, sv, pend[u]);
        chk({t, "_stable_idx"}, si, stab[u]);
        pend[u] = 0;
        if (due) begin
            if (!lst[u].conf) cnt[u] = 0;
            else if (lst[u].idx == cand[u]) cnt[u] = cnt[u] + 1 > H ? H : cnt[u] + 1;
            else begin
                cand[u] = lst[u].idx;
                cnt[u] = 1;
            end
            if (cnt[u] == H && cand[u] != stab[u]) begin
                stab[u] = cand[u];
                pend[u] = 1;
            end
        end
`else
        chk({t, "_stable_vld"}, sv, due);
        chk({t, "_stable_idx"}, si, lst[u].idx);
`endif
    endtask

    always @(negedge clk)
        if (!reset) begin
            mon(0, "u", v_u, d_u, i_u, c_u, si_u, sv_u);
            mon(1, "s", v_s, d_s, i_s, c_s, si_s, sv_s);
            mon(2, "p", v_p, d_p, {2'b0, i_p}, c_p, {2'b0, si_p}, sv_p);
        end

    task automatic chk_zero(input string t);
        chk({t, "_zero_u"}, {d_u, i_u, c_u, v_u, si_u, sv_u}, 0);
        chk({t, "_zero_s"}, {d_s, i_s, c_s, v_s, si_s, sv_s}, 0);
        chk({t, "_zero_p"}, {d_p, i_p, c_p, v_p, si_p, sv_p}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] v;
        logic [NP*W-1:0] vp;
        flush();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        reset = 0;
        v = {N{8'h10}};
        v[W*17 +: W] = 8'hF0;
        send(v, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t1_valid", v_u, 1);
        chk("t1_idx", i_u, 17);
        chk("t1_data", d_u, 8'hF0);
        chk("t1_conf", c_u, 1);
        v = {N{8'h55}};
        v[W*5 +: W] = 8'h01;
        v[W*20 +: W] = 8'h01;
        send(v, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_idx", i_u, 5);
        chk("t2_data", d_u, 8'h01);
        v = {N{8'hFF}};
        v[0 +: W] = 8'h7F;
        v[W*23 +: W] = 8'h80;
        send(v, 0);
        send(v, 1);
        @(posedge clk);
        #1;
        chk("t3_signed_max_idx", i_s, 0);
        @(posedge clk);
        #1;
        chk("t3_signed_min_idx", i_s, 23);
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) v[W*j +: W] = W'($urandom_range(8'h20, 8'hD0));
            v[W*i +: W] = i[0] ? 8'h05 : 8'hF5;
            send(v, i[0]);
        end
        repeat (4) tick();
        send_p({NP{8'h00}}, 0);
        @(posedge clk);
        #1;
        chk("t5_pad_valid", v_p, 1);
        chk("t5_pad_idx", i_p, 0);
        send_p({NP{8'hFF}}, 1);
        @(posedge clk);
        #1;
        chk("t5_pad_min_idx", i_p, 0);
        chk("t5_pad_min_data", d_p, 8'hFF);
        foreach (v[b]) v[b] = 1'b0;
        for (int f = 0; f < 6; f++) begin
            int w = f == 2 ? 9 : 4;
            v = {N{8'h10}};
            v[W*w +: W] = 8'hF0;
            send(v, 0);
        end
        repeat (5) tick();
        send(v, 0);
        send(v, 1);
        reset = 1;
        flush();
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        reset = 0;
        send(v, 0);
        repeat (4) tick();
        for (int p = 0; p < 4; p++) begin
            thresh_i = W'($urandom);
            repeat (150) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int j = 0; j < N; j++) v[W*j +: W] = p[0] ? W'($urandom) : W'($urandom_range(0, 3));
                    put(v, 1'($urandom_range(0, 1)));
                end
                if ($urandom_range(0, 2) != 0) begin
                    for (int j = 0; j < NP; j++) vp[W*j +: W] = p[0] ? W'($urandom) : W'($urandom_range(0, 2));
                    put_p(vp, 1'($urandom_range(0, 1)));
                end
                tick();
            end
            repeat (5) tick();
        end
        chk("queues_drained", q[0].size() + q[1].size() + q[2].size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
